// File: rtl/uart_secded_pkg.sv
// Shared types and constants for the UART SEC-DED receiver.
//   entry_t    : one decoded frame as stored in the output FIFO (9 bits)
//   rx_state_e : receive FSM states
//   POS_*      : zero-based bit positions of each code bit in received order
//   data_pos() : maps data index 0..3 (d1..d4) to its code bit position
package uart_secded_pkg;

    typedef struct packed {
        logic       uncorrectable;
        logic       corrected;
        logic [2:0] syndrome;
        logic [3:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    // Received order p1 p2 d1 p4 d2 d3 d4 [parity]; Hamming position = POS_* + 1.
    localparam int POS_P1  = 0;
    localparam int POS_P2  = 1;
    localparam int POS_D1  = 2;
    localparam int POS_P4  = 3;
    localparam int POS_D2  = 4;
    localparam int POS_D3  = 5;
    localparam int POS_D4  = 6;
    localparam int POS_PAR = 7;

    function automatic int data_pos(input int i);
        case (i)
            0:       return POS_D1;
            1:       return POS_D2;
            2:       return POS_D3;
            default: return POS_D4;
        endcase
    endfunction

endpackage

// File: rtl/hamming_secded_decode.sv
// Combinational Hamming(7,4) decoder with optional overall-parity bit.
//   code          : received code word, bit 0 = position 1 (p1)
//   data          : corrected data {d4,d3,d2,d1}
//   syndrome      : {s4,s2,s1}
//   corrected     : a single-bit error was fixed (or only the parity bit was wrong)
//   uncorrectable : double error detected (SECDED=1 only)
module hamming_secded_decode
    import uart_secded_pkg::*;
#(
    parameter int SECDED = 1
) (
    input  logic [6+SECDED:0] code,
    output logic [3:0]        data,
    output logic [2:0]        syndrome,
    output logic              corrected,
    output logic              uncorrectable
);

    logic       s1;
    logic       s2;
    logic       s4;
    logic [2:0] syn;
    logic       flip_en;

    assign s1  = code[POS_P1] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D4];
    assign s2  = code[POS_P2] ^ code[POS_D1] ^ code[POS_D3] ^ code[POS_D4];
    assign s4  = code[POS_P4] ^ code[POS_D2] ^ code[POS_D3] ^ code[POS_D4];
    assign syn = {s4, s2, s1};
    assign syndrome = syn;

    generate
        if (SECDED != 0) begin : g_secded
            logic parity_err;
            assign parity_err    = code[POS_PAR] ^ (^code[6:0]);
            // Odd overall parity means exactly one bit flipped: either the one
            // the syndrome points at, or the parity bit itself when s == 0.
            assign flip_en       = (syn != 3'd0) && parity_err;
            assign corrected     = parity_err;
            assign uncorrectable = (syn != 3'd0) && !parity_err;
        end else begin : g_hamming
            assign flip_en       = (syn != 3'd0);
            assign corrected     = flip_en;
            assign uncorrectable = 1'b0;
        end
    endgenerate

    // Only data positions need the correction applied; parity bits are dropped.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_data
            assign data[gi] = code[data_pos(gi)] ^
                              (flip_en && (syn == 3'(data_pos(gi) + 1)));
        end
    endgenerate

endmodule

// File: rtl/uart_secded_rx.sv
// UART receiver with Hamming / SEC-DED decoding and a show-ahead output FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   rx              : serial input, idle high, LSB first
//   m_data          : head entry data {d4,d3,d2,d1}
//   m_syndrome      : head entry syndrome {s4,s2,s1}
//   m_corrected     : head entry had a corrected error
//   m_uncorrectable : head entry had a double error
//   m_valid/m_ready : head handshake, pop on m_valid && m_ready
//   frame_err       : one-cycle pulse, stop bit sampled low
//   overflow        : one-cycle pulse, frame dropped on full FIFO
//   fifo_count      : current FIFO occupancy
module uart_secded_rx
    import uart_secded_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SECDED       = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    output logic [3:0]                        m_data,
    output logic [2:0]                        m_syndrome,
    output logic                              m_corrected,
    output logic                              m_uncorrectable,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              frame_err,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int N  = 7 + SECDED;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(N - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    // Synchroniser and edge detect
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic rx_prev_q, rx_prev_d;
    logic fall;

    // Receive FSM and datapath
    rx_state_e      state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     idx_q, idx_d;
    logic [N-1:0]   shift_q, shift_d;

    // Output pulses
    logic frame_err_q, frame_err_d;
    logic overflow_q, overflow_d;

    // FIFO
    entry_t         mem_q [FIFO_DEPTH];
    entry_t         mem_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic   stop_sample;
    logic   stop_ok;
    logic   push;
    logic   pop;
    logic   full;
    logic   valid;
    entry_t dec_entry;
    entry_t head;

    logic [3:0] dec_data;
    logic [2:0] dec_syn;
    logic       dec_corr;
    logic       dec_unc;

    hamming_secded_decode #(
        .SECDED(SECDED)
    ) u_decode (
        .code         (shift_q),
        .data         (dec_data),
        .syndrome     (dec_syn),
        .corrected    (dec_corr),
        .uncorrectable(dec_unc)
    );

    assign dec_entry = '{uncorrectable: dec_unc, corrected: dec_corr,
                         syndrome: dec_syn, data: dec_data};

    assign rx_meta_d = rx;
    assign rx_sync_d = rx_meta_q;
    assign rx_prev_d = rx_sync_q;
    assign fall      = rx_prev_q && !rx_sync_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
        // Storage needs no reset: the read side is qualified by the count.
        mem_q <= mem_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        state_d = ST_IDLE;    // glitch, not a real start bit
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d          = '0;
                    shift_d[idx_q]   = rx_sync_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: stop-bit evaluation and FIFO control
    always_comb begin
        stop_sample = (state_q == ST_STOP) && (timer_q == FULL_M1);
        stop_ok     = stop_sample && rx_sync_q;
        valid       = (count_q != '0);
        full        = (count_q == DEPTH_C);
        pop         = valid && m_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push        = stop_ok && (!full || pop);
        frame_err_d = stop_sample && !rx_sync_q;
        overflow_d  = stop_ok && full && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign head            = mem_q[rd_ptr_q];
    assign m_valid         = valid;
    assign m_data          = valid ? head.data : 4'd0;
    assign m_syndrome      = valid ? head.syndrome : 3'd0;
    assign m_corrected     = valid && head.corrected;
    assign m_uncorrectable = valid && head.uncorrectable;
    assign frame_err       = frame_err_q;
    assign overflow        = overflow_q;
    assign fifo_count      = count_q;

endmodule
